// File: rtl/key_cond_pkg.sv
// Shared definitions for the key conditioner: FSM state encoding and default sizing.
package key_cond_pkg;

    typedef enum logic [1:0] {
        IDLE_LO = 2'b00,
        WAIT_HI = 2'b01,
        IDLE_HI = 2'b10,
        WAIT_LO = 2'b11
    } key_state_t;

    localparam int DEF_STABLE_CYCLES = 500000;
    localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer for bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/key_conditioner.sv
// Debounces a raw key level: synchronizes it, requires STABLE_CYCLES of a steady new level,
// then reports the registered level, edge pulses and a wrapping press count.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_i,
    output logic             key_o,
    output logic             key_rise,
    output logic             key_fall,
    output logic [CNT_W-1:0] press_cnt,
    output logic [1:0]       o_dbg_state
);

    localparam int             CW      = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

    logic             w_k_s;
    key_state_t       r_state;
    key_state_t       w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_next_cnt;
    logic             w_rise;
    logic             w_fall;
    logic             r_key_o;
    logic             r_key_rise;
    logic             r_key_fall;
    logic [CNT_W-1:0] r_press_cnt;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (key_i),
        .o_q   (w_k_s)
    );

    // cnt only advances inside a WAIT state; every other path leaves it at 0.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = '0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        case (r_state)
            IDLE_LO: if (w_k_s) w_next_state = WAIT_HI;
            WAIT_HI: begin
                if (!w_k_s) begin
                    w_next_state = IDLE_LO;
                end else if (r_cnt == CNT_MAX) begin
                    w_next_state = IDLE_HI;
                    w_rise       = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            IDLE_HI: if (!w_k_s) w_next_state = WAIT_LO;
            WAIT_LO: begin
                if (w_k_s) begin
                    w_next_state = IDLE_HI;
                end else if (r_cnt == CNT_MAX) begin
                    w_next_state = IDLE_LO;
                    w_fall       = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CW'(1);
                end
            end
            default: w_next_state = IDLE_LO;
        endcase
    end

    // key_o has its own flop so it can safely drive a downstream clock or reset pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE_LO;
            r_cnt       <= '0;
            r_key_o     <= 1'b0;
            r_key_rise  <= 1'b0;
            r_key_fall  <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_key_o    <= (w_next_state == IDLE_HI) || (w_next_state == WAIT_LO);
            r_key_rise <= w_rise;
            r_key_fall <= w_fall;
            if (w_rise) r_press_cnt <= r_press_cnt + CNT_W'(1);
        end
    end

    assign key_o       = r_key_o;
    assign key_rise    = r_key_rise;
    assign key_fall    = r_key_fall;
    assign press_cnt   = r_press_cnt;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with STABLE_CYCLES=4: latency, bounce, glitch, wrap and reset cases.
module tb_key_conditioner;

    localparam int STABLE_CYCLES = 4;
    localparam int CNT_W         = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             key_i;
    logic             key_o;
    logic             key_rise;
    logic             key_fall;
    logic [CNT_W-1:0] press_cnt;
    logic [1:0]       o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_rise   = 0;
    int n_fall   = 0;
    int r0;
    int f0;

    key_conditioner #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_i       (key_i),
        .key_o       (key_o),
        .key_rise    (key_rise),
        .key_fall    (key_fall),
        .press_cnt   (press_cnt),
        .o_dbg_state (o_dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic eo, input logic er, input logic ef,
                           input logic [CNT_W-1:0] ep);
        chk({tag, ".key_o"},     {31'd0, key_o},    {31'd0, eo});
        chk({tag, ".key_rise"},  {31'd0, key_rise}, {31'd0, er});
        chk({tag, ".key_fall"},  {31'd0, key_fall}, {31'd0, ef});
        chk({tag, ".press_cnt"}, {24'd0, press_cnt}, {24'd0, ep});
    endtask

    task automatic do_reset();
        key_i = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
    endtask

    // Pulse tally plus mutual-exclusion check, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (key_rise === 1'b1) n_rise++;
            if (key_fall === 1'b1) n_fall++;
            chk("rise_fall_excl", {31'd0, key_rise & key_fall}, 32'd0);
        end
    end

    initial begin
        key_i = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk_out("in_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("in_reset.state", {30'd0, o_dbg_state}, 32'd0);
        reset = 1'b0;

        // Key held low for 50 cycles
        for (int e = 1; e <= 50; e++) tick();
        chk_out("idle_low", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("idle_low.rises", n_rise, 32'd0);
        chk("idle_low.falls", n_fall, 32'd0);

        // Clean press: key_o rises on edge 7
        key_i = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk_out($sformatf("press_e%0d", e), (e >= 7), (e == 7), 1'b0, (e >= 7) ? 8'd1 : 8'd0);
        end
        chk("press.rises", n_rise, 32'd1);

        // Clean release: key_o falls on edge 7
        key_i = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk_out($sformatf("release_e%0d", e), (e < 7), 1'b0, (e == 7), 8'd1);
        end
        chk("release.falls", n_fall, 32'd1);

        // Bounce: 3 high / 2 low, three times, then held high
        do_reset();
        r0 = n_rise;
        for (int rep = 0; rep < 3; rep++) begin
            key_i = 1'b1;
            for (int e = 0; e < 3; e++) begin
                tick();
                chk_out($sformatf("bounce_r%0d_hi%0d", rep, e), 1'b0, 1'b0, 1'b0, 8'd0);
            end
            key_i = 1'b0;
            for (int e = 0; e < 2; e++) begin
                tick();
                chk_out($sformatf("bounce_r%0d_lo%0d", rep, e), 1'b0, 1'b0, 1'b0, 8'd0);
            end
        end
        key_i = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk_out($sformatf("bounce_hold_e%0d", e), (e >= 7), (e == 7), 1'b0, (e >= 7) ? 8'd1 : 8'd0);
        end
        chk("bounce.rises", n_rise - r0, 32'd1);

        // 4-cycle low glitch on a high key
        f0 = n_fall;
        key_i = 1'b0;
        for (int e = 0; e < 4; e++) tick();
        key_i = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk_out($sformatf("lo_glitch_e%0d", e), 1'b1, 1'b0, 1'b0, 8'd1);
        end
        chk("lo_glitch.falls", n_fall - f0, 32'd0);

        // Release, then a 4-cycle high glitch on a low key
        key_i = 1'b0;
        for (int e = 0; e < 10; e++) tick();
        chk_out("pre_hi_glitch", 1'b0, 1'b0, 1'b0, 8'd1);
        r0 = n_rise;
        key_i = 1'b1;
        for (int e = 0; e < 4; e++) tick();
        key_i = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk_out($sformatf("hi_glitch_e%0d", e), 1'b0, 1'b0, 1'b0, 8'd1);
        end
        chk("hi_glitch.rises", n_rise - r0, 32'd0);

        // 5-cycle high pulse is one cycle longer than the rejection window
        key_i = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e == 5) key_i = 1'b0;
            chk_out($sformatf("pulse5_e%0d", e), (e >= 7) && (e < 12), (e == 7), (e == 12),
                    (e >= 7) ? 8'd2 : 8'd1);
        end

        // 256 clean presses wrap the counter
        do_reset();
        r0 = n_rise;
        f0 = n_fall;
        for (int p = 1; p <= 256; p++) begin
            key_i = 1'b1;
            for (int e = 0; e < 8; e++) tick();
            if (p == 255) chk("wrap.cnt255", {24'd0, press_cnt}, 32'd255);
            key_i = 1'b0;
            for (int e = 0; e < 8; e++) tick();
        end
        chk("wrap.press_cnt", {24'd0, press_cnt}, 32'd0);
        chk("wrap.rises", n_rise - r0, 32'd256);
        chk("wrap.falls", n_fall - f0, 32'd256);

        // Reset pulse while in WAIT_HI with cnt=2, key held high
        do_reset();
        key_i = 1'b1;
        for (int e = 0; e < 5; e++) tick();
        chk("wait_hi.state", {30'd0, o_dbg_state}, 32'd1);
        chk_out("wait_hi", 1'b0, 1'b0, 1'b0, 8'd0);
        r0 = n_rise;
        reset = 1'b1;
        #1;
        chk("async_reset.state", {30'd0, o_dbg_state}, 32'd0);
        chk_out("async_reset", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        chk_out("reset_held", 1'b0, 1'b0, 1'b0, 8'd0);
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk_out($sformatf("post_reset_e%0d", e), (e >= 7), (e == 7), 1'b0, (e >= 7) ? 8'd1 : 8'd0);
        end
        chk("post_reset.rises", n_rise - r0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter STABLE_CYCLES, default 500000, SHALL set the number of cycles a new key level must hold before it is accepted (10 ms at 50 MHz); legal range 2..2^24.
REQ-002 Parameter CNT_W, default 8, SHALL set the press counter width.
REQ-003 Port clk, input, 1: the single system clock; every flop in the block SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1: reset, asynchronous and active-high.
REQ-005 Port key_i, input, 1: raw mechanical key or switch level, asynchronous to clk and bouncing.
REQ-006 Port key_o, output, 1: debounced, registered key level.
REQ-007 Port key_rise, output, 1: one-cycle pulse, asserted when key_o goes 0->1.
REQ-008 Port key_fall, output, 1: one-cycle pulse, asserted when key_o goes 1->0.
REQ-009 Port press_cnt, output, CNT_W: count of accepted presses.

Function
REQ-010 key_i SHALL pass through a two-flop synchronizer; its output is k_s, and k_s SHALL be the only signal that reads key_i.
REQ-011 The block SHALL contain an FSM with four states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
REQ-012 In IDLE_LO: k_s=1 -> go to WAIT_HI with cnt cleared to 0; otherwise stay.
REQ-013 In WAIT_HI: k_s=0 -> go to IDLE_LO with cnt cleared and no output change.
- k_s=1 and cnt=STABLE_CYCLES-1 -> go to IDLE_HI.
- k_s=1 otherwise -> cnt increments.
REQ-014 IDLE_HI and WAIT_LO SHALL mirror REQ-012 and REQ-013 with the levels inverted.
REQ-015 key_o SHALL be 1 exactly when the state is IDLE_HI or WAIT_LO, and SHALL be registered.
REQ-016 Latency: for a clean key_i edge, key_o SHALL change on clock edge STABLE_CYCLES+3, where edge 1 is the first edge that samples the new key_i level.
REQ-017 Glitch rejection: any k_s excursion lasting STABLE_CYCLES or fewer cycles SHALL leave key_o, key_rise, key_fall and press_cnt unchanged.
REQ-018 key_rise SHALL be high in exactly the cycle in which key_o is first 1; key_fall likewise in the cycle key_o is first 0; both are registered and never high together.
REQ-019 press_cnt SHALL increment by 1 on the same edge that sets key_rise.
REQ-020 press_cnt SHALL wrap from 2^CNT_W-1 to 0 with no flag.
REQ-021 cnt width SHALL be clog2(STABLE_CYCLES).
REQ-022 cnt SHALL never exceed STABLE_CYCLES-1.
REQ-023 cnt SHALL hold 0 in the IDLE states.

Reset
REQ-024 While reset=1, the block SHALL immediately force:
- state to IDLE_LO;
- synchronizer flops, cnt, key_o, key_rise, key_fall and press_cnt to 0.
REQ-025 After reset is released, a key_i already held at 1 SHALL be treated as a new press: full REQ-016 latency, then key_rise and a press_cnt increment.
REQ-026 Reset asserted during WAIT_HI or WAIT_LO SHALL discard the pending transition; no pulse SHALL be generated for it.

Structure
REQ-027 Package key_cond_pkg SHALL hold:
- the FSM state enum (2-bit encoding);
- the default STABLE_CYCLES and CNT_W constants.
REQ-028 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, with clk and reset), reusable for other asynchronous inputs in the codebase.
REQ-029 key_o SHALL be suitable as the clock or reset source of a downstream shift-register stage; it SHALL come straight from a flop with no combinational logic after it.

Verification (STABLE_CYCLES=4, CNT_W=8)
REQ-030 Reset, then key_i held at 0 for 50 cycles -> key_o, key_rise, key_fall and press_cnt all stay 0.
REQ-031 key_i steps 0->1 and holds for 20 cycles -> key_o rises on edge 7; key_rise is high for exactly 1 cycle; press_cnt=1; key_fall stays 0.
REQ-032 Bounce: key_i high 3 cycles, low 2 cycles, repeated 3 times, then held high -> exactly one key_rise; press_cnt=1; key_o rises 7 edges after the last 0->1.
REQ-033 A 4-cycle high glitch on a low key, and separately a 4-cycle low glitch on a high key -> no change on any output.
REQ-034 256 clean presses, each followed by a clean release -> press_cnt wraps to 0; 256 key_rise and 256 key_fall pulses are counted.
REQ-035 Reset pulsed for 1 cycle while in WAIT_HI (cnt=2), with key_i held at 1 throughout -> outputs are 0 during reset; one key_rise occurs 7 edges after reset release; press_cnt=1.
